// File: rtl/if_bus_if.sv
// Instruction-fetch bus interface: one outstanding bus read per fetch, with stall hold and flush discard.
// Optional scratchpad fast path enabled by defining IF_SPM_EN.
module if_bus_if (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] insn,
  output logic        busy,
  output logic        bus_req,
  input  logic        bus_grnt,
  output logic [29:0] bus_addr,
  output logic        bus_as,
  output logic        bus_rw,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy
`ifdef IF_SPM_EN
  ,
  output logic [11:0] spm_addr,
  output logic        spm_as,
  input  logic [31:0] spm_rd_data
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, HOLD} state_t;

  state_t      state;
  logic [31:0] rd_buf;
  logic        flush_lat;
  logic        discard;
  logic        spm_hit;

`ifdef IF_SPM_EN
  assign spm_hit  = (addr[29:12] == 18'h0);
  assign spm_as   = (state == IDLE) && spm_hit;
  assign spm_addr = addr[11:0];
`else
  assign spm_hit  = 1'b0;
`endif

  assign bus_rw  = 1'b1;
  assign discard = flush_lat | flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_as    <= 1'b0;
      bus_addr  <= '0;
      rd_buf    <= NOP;
      flush_lat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus_as    <= 1'b0;
          flush_lat <= 1'b0;
          if (!flush && !spm_hit) begin
            bus_req  <= 1'b1;
            bus_addr <= addr;
            state    <= REQ;
          end
        end
        REQ: begin
          // A grant wins over a same-cycle flush; the flush is remembered so the data is dropped.
          if (bus_grnt) begin
            bus_as    <= 1'b1;
            flush_lat <= flush;
            state     <= ACCESS;
          end else if (flush) begin
            bus_req <= 1'b0;
            state   <= IDLE;
          end
        end
        ACCESS: begin
          bus_as <= 1'b0;
          if (bus_rdy) begin
            bus_req   <= 1'b0;
            rd_buf    <= discard ? NOP : bus_rd_data;
            flush_lat <= 1'b0;
            state     <= stall ? HOLD : IDLE;
          end else if (flush) begin
            flush_lat <= 1'b1;
          end
        end
        HOLD: begin
          if (flush || !stall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    insn = NOP;
    busy = 1'b0;
    case (state)
      IDLE: begin
        busy = !flush && !spm_hit;
`ifdef IF_SPM_EN
        if (spm_hit && !flush) begin
          insn = spm_rd_data;
        end
`endif
      end
      REQ: begin
        busy = 1'b1;
      end
      ACCESS: begin
        if (bus_rdy) begin
          insn = discard ? NOP : bus_rd_data;
        end else begin
          busy = 1'b1;
        end
      end
      HOLD: begin
        insn = flush ? NOP : rd_buf;
      end
      default: begin
        insn = NOP;
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_if_bus_if.sv
// Self-checking bench for if_bus_if: scenario tasks with a queue of expected fetch results.
// Define IF_SPM_EN on both files to include the scratchpad scenario.
module tb_if_bus_if;

  logic        clk;
  logic        reset;
  logic [29:0] addr;
  logic        stall;
  logic        flush;
  logic [31:0] insn;
  logic        busy;
  logic        bus_req;
  logic        bus_grnt;
  logic [29:0] bus_addr;
  logic        bus_as;
  logic        bus_rw;
  logic [31:0] bus_rd_data;
  logic        bus_rdy;
`ifdef IF_SPM_EN
  logic [11:0] spm_addr;
  logic        spm_as;
  logic [31:0] spm_rd_data;
`endif

  int errors = 0;
  int checks = 0;
  int as_count = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  if_bus_if dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .stall      (stall),
    .flush      (flush),
    .insn       (insn),
    .busy       (busy),
    .bus_req    (bus_req),
    .bus_grnt   (bus_grnt),
    .bus_addr   (bus_addr),
    .bus_as     (bus_as),
    .bus_rw     (bus_rw),
    .bus_rd_data(bus_rd_data),
    .bus_rdy    (bus_rdy)
`ifdef IF_SPM_EN
    ,
    .spm_addr   (spm_addr),
    .spm_as     (spm_as),
    .spm_rd_data(spm_rd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_as === 1'b1) as_count++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    sample();
    checks++; if (insn !== 32'h0) begin errors++; $display("[TB] FAIL rst_insn: got %h expected 00000000", insn); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_bus_req: got %b expected 0", bus_req); end
    checks++; if (bus_as !== 1'b0) begin errors++; $display("[TB] FAIL rst_bus_as: got %b expected 0", bus_as); end
    checks++; if (bus_rw !== 1'b1) begin errors++; $display("[TB] FAIL rst_bus_rw: got %b expected 1", bus_rw); end
    checks++; if (bus_addr !== 30'h0) begin errors++; $display("[TB] FAIL rst_bus_addr: got %h expected 0", bus_addr); end
    cycle();
    reset = 1'b0;
    cycle();
    sample();
    checks++; if (bus_req !== 1'b0 || busy !== 1'b0 || insn !== 32'h0) begin errors++; $display("[TB] FAIL idle_flush: got req=%b busy=%b insn=%h expected 0 0 00000000", bus_req, busy, insn); end
  endtask

  task automatic test_basic_fetch();
    int as0 = as_count;
    addr = 30'h0000_1000; flush = 1'b0;
    sample();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_idle: got %b expected 1", busy); end
    cycle();
    bus_grnt = 1'b1;
    sample();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_req: got %b expected 1", busy); end
    checks++; if (bus_req !== 1'b1) begin errors++; $display("[TB] FAIL basic_bus_req: got %b expected 1", bus_req); end
    checks++; if (bus_addr !== 30'h0000_1000) begin errors++; $display("[TB] FAIL basic_bus_addr: got %h expected 00001000", bus_addr); end
    cycle();
    bus_grnt = 1'b0; bus_rdy = 1'b1; bus_rd_data = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    sample();
    checks++; if (bus_as !== 1'b1) begin errors++; $display("[TB] FAIL basic_bus_as: got %b expected 1", bus_as); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_rdy: got %b expected 0", busy); end
    exp = exp_q.pop_front();
    checks++; if (insn !== exp) begin errors++; $display("[TB] FAIL basic_insn: got %h expected %h", insn, exp); end
    cycle();
    bus_rdy = 1'b0; flush = 1'b1;
    sample();
    checks++; if (bus_req !== 1'b0 || bus_as !== 1'b0) begin errors++; $display("[TB] FAIL basic_release: got req=%b as=%b expected 0 0", bus_req, bus_as); end
    checks++; if (as_count - as0 !== 1) begin errors++; $display("[TB] FAIL basic_as_pulses: got %0d expected 1", as_count - as0); end
  endtask

  task automatic test_wait_states();
    int as0 = as_count;
    addr = 30'h0000_2000; flush = 1'b0;
    sample();
    cycle();
    bus_rdy = 1'b1; bus_rd_data = 32'h1111_1111;
    sample();
    checks++; if (busy !== 1'b1 || insn !== 32'h0) begin errors++; $display("[TB] FAIL stray_rdy: got busy=%b insn=%h expected 1 00000000", busy, insn); end
    cycle();
    bus_rdy = 1'b0; bus_grnt = 1'b1;
    sample();
    cycle();
    bus_grnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      checks++; if (busy !== 1'b1 || bus_req !== 1'b1) begin errors++; $display("[TB] FAIL wait_hold%0d: got busy=%b req=%b expected 1 1", i, busy, bus_req); end
      cycle();
    end
    bus_rdy = 1'b1; bus_rd_data = 32'hA5A5_0F0F;
    exp_q.push_back(32'hA5A5_0F0F);
    sample();
    exp = exp_q.pop_front();
    checks++; if (insn !== exp || busy !== 1'b0) begin errors++; $display("[TB] FAIL wait_insn: got insn=%h busy=%b expected %h 0", insn, busy, exp); end
    cycle();
    bus_rdy = 1'b0; flush = 1'b1;
    sample();
    checks++; if (as_count - as0 !== 1) begin errors++; $display("[TB] FAIL wait_as_pulses: got %0d expected 1", as_count - as0); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL wait_release: got %b expected 0", bus_req); end
  endtask

  task automatic test_stall_hold();
    addr = 30'h0000_3000; flush = 1'b0;
    sample();
    cycle();
    bus_grnt = 1'b1;
    sample();
    cycle();
    bus_grnt = 1'b0; bus_rdy = 1'b1; bus_rd_data = 32'h1234_5678; stall = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h1234_5678);
    sample();
    exp = exp_q.pop_front();
    checks++; if (insn !== exp) begin errors++; $display("[TB] FAIL stall_rdy_insn: got %h expected %h", insn, exp); end
    cycle();
    bus_rdy = 1'b0; bus_rd_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      sample();
      exp = exp_q.pop_front();
      checks++; if (insn !== exp || busy !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold%0d: got insn=%h busy=%b req=%b expected %h 0 0", i, insn, busy, bus_req, exp); end
      cycle();
    end
    stall = 1'b0;
    sample();
    exp = exp_q.pop_front();
    checks++; if (insn !== exp || bus_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_release: got insn=%h req=%b expected %h 0", insn, bus_req, exp); end
    cycle();
    flush = 1'b1;
    sample();
    checks++; if (insn !== 32'h0 || bus_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_idle: got insn=%h req=%b expected 00000000 0", insn, bus_req); end
  endtask

  task automatic test_flush_access();
    int as0 = as_count;
    addr = 30'h0000_4000; flush = 1'b0;
    sample();
    cycle();
    bus_grnt = 1'b1;
    sample();
    cycle();
    bus_grnt = 1'b0; flush = 1'b1;
    sample();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_acc_busy: got %b expected 1", busy); end
    cycle();
    flush = 1'b0; bus_rdy = 1'b1; bus_rd_data = 32'h5555_AAAA;
    exp_q.push_back(32'h0000_0000);
    sample();
    exp = exp_q.pop_front();
    checks++; if (insn !== exp || busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_acc_nop: got insn=%h busy=%b expected %h 0", insn, busy, exp); end
    cycle();
    bus_rdy = 1'b0; addr = 30'h0000_4100;
    sample();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_next_busy: got %b expected 1", busy); end
    cycle();
    bus_grnt = 1'b1;
    sample();
    checks++; if (bus_addr !== 30'h0000_4100 || bus_req !== 1'b1) begin errors++; $display("[TB] FAIL flush_next_addr: got addr=%h req=%b expected 00004100 1", bus_addr, bus_req); end
    cycle();
    bus_grnt = 1'b0; bus_rdy = 1'b1; bus_rd_data = 32'h0BAD_F00D;
    exp_q.push_back(32'h0BAD_F00D);
    sample();
    exp = exp_q.pop_front();
    checks++; if (insn !== exp) begin errors++; $display("[TB] FAIL flush_next_insn: got %h expected %h", insn, exp); end
    cycle();
    bus_rdy = 1'b0; flush = 1'b1;
    sample();
    checks++; if (as_count - as0 !== 2) begin errors++; $display("[TB] FAIL flush_as_pulses: got %0d expected 2", as_count - as0); end
  endtask

  task automatic test_flush_req();
    int as0 = as_count;
    addr = 30'h0000_6000; flush = 1'b0;
    sample();
    cycle();
    flush = 1'b1;
    sample();
    checks++; if (insn !== 32'h0 || bus_req !== 1'b1) begin errors++; $display("[TB] FAIL flush_req_cycle: got insn=%h req=%b expected 00000000 1", insn, bus_req); end
    cycle();
    sample();
    checks++; if (bus_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_req_drop: got req=%b busy=%b expected 0 0", bus_req, busy); end
    checks++; if (as_count - as0 !== 0) begin errors++; $display("[TB] FAIL flush_req_as: got %0d expected 0", as_count - as0); end
  endtask

  task automatic test_reset_mid();
    int as0 = as_count;
    addr = 30'h0000_5000; flush = 1'b0;
    sample();
    cycle();
    bus_grnt = 1'b1;
    sample();
    cycle();
    bus_grnt = 1'b0;
    sample();
    #1;
    reset = 1'b1; flush = 1'b1;
    #1;
    checks++; if (bus_req !== 1'b0 || bus_as !== 1'b0 || insn !== 32'h0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_async: got req=%b as=%b insn=%h busy=%b expected 0 0 00000000 0", bus_req, bus_as, insn, busy); end
    cycle();
    reset = 1'b0; bus_rdy = 1'b1; bus_rd_data = 32'hFFFF_FFFF;
    sample();
    checks++; if (insn !== 32'h0 || busy !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_late_rdy: got insn=%h busy=%b req=%b expected 00000000 0 0", insn, busy, bus_req); end
    cycle();
    bus_rdy = 1'b0;
    sample();
    checks++; if (as_count - as0 !== 1 || bus_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_after: got pulses=%0d req=%b expected 1 0", as_count - as0, bus_req); end
  endtask

`ifdef IF_SPM_EN
  task automatic test_spm();
    addr = 30'h0000_0010; spm_rd_data = 32'hCAFE_0001; flush = 1'b0;
    exp_q.push_back(32'hCAFE_0001);
    sample();
    exp = exp_q.pop_front();
    checks++; if (insn !== exp || busy !== 1'b0) begin errors++; $display("[TB] FAIL spm_insn: got insn=%h busy=%b expected %h 0", insn, busy, exp); end
    checks++; if (spm_as !== 1'b1 || spm_addr !== 12'h010) begin errors++; $display("[TB] FAIL spm_strobe: got as=%b addr=%h expected 1 010", spm_as, spm_addr); end
    stall = 1'b1;
    cycle();
    sample();
    checks++; if (spm_as !== 1'b1 || spm_addr !== 12'h010 || bus_req !== 1'b0) begin errors++; $display("[TB] FAIL spm_stall: got as=%b addr=%h req=%b expected 1 010 0", spm_as, spm_addr, bus_req); end
    cycle();
    stall = 1'b0; flush = 1'b1;
    sample();
  endtask
`endif

  initial begin
    reset = 1'b1; flush = 1'b1; stall = 1'b0; addr = '0;
    bus_grnt = 1'b0; bus_rdy = 1'b0; bus_rd_data = '0;
`ifdef IF_SPM_EN
    spm_rd_data = '0;
`endif
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_stall_hold();
    test_flush_access();
    test_flush_req();
    test_reset_mid();
`ifdef IF_SPM_EN
    test_spm();
`endif
    checks++; if (exp_q.size() !== 0) begin errors++; $display("[TB] FAIL scoreboard_empty: got %0d expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
